qa_drv_c1_write_scheduler: RTL and testbench

//  Shares CCI channel-1 (write) between N driver-internal requesters (frame writer,

---
 rtl/qa_drv_c1_write_scheduler_pkg.sv | 13 +
 rtl/qa_drv_c1_write_scheduler_rr_pick.sv | 24 ++
 rtl/qa_drv_c1_write_scheduler.sv | 80 ++++++++
 tb/tb_qa_drv_c1_write_scheduler.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/qa_drv_c1_write_scheduler_pkg.sv
// qa_drv_c1_write_scheduler_pkg: shared types, defaults and helpers for the C1 write scheduler
package qa_drv_c1_write_scheduler_pkg;
  localparam int C1_HDR_WIDTH = 61;
  localparam int C1_DATA_WIDTH = 512;
  localparam int DEF_MAX_OUTSTANDING = 64;
  typedef struct packed {
    logic [C1_HDR_WIDTH-1:0] hdr;
    logic [C1_DATA_WIDTH-1:0] data;
  } t_C1_WR_REQ;
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction
endpackage

// File: rtl/qa_drv_c1_write_scheduler_rr_pick.sv
// qa_drv_rr_pick: combinational round-robin picker starting after the last granted index
module qa_drv_rr_pick
  import qa_drv_c1_write_scheduler_pkg::*;
#(
  parameter int N = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);
  // Walk farthest-first so the nearest valid requester after ptr_i is the last write
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    for (int k = N; k >= 1; k--)
      if (en_i && valid_i[IW'(wrap_add(int'(ptr_i), k, N))]) begin
        idx_o = IW'(wrap_add(int'(ptr_i), k, N));
        grant_o = N'(1) << idx_o;
      end
  end
endmodule

// File: rtl/qa_drv_c1_write_scheduler.sv
// qa_drv_c1_write_scheduler: round-robin sharing of CCI C1 writes with an outstanding-write credit cap
module qa_drv_c1_write_scheduler
  import qa_drv_c1_write_scheduler_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int HDR_WIDTH = C1_HDR_WIDTH,
  parameter int DATA_WIDTH = C1_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N_REQ-1:0]                     req_valid,
  input  logic [N_REQ*HDR_WIDTH-1:0]           req_hdr,
  input  logic [N_REQ*DATA_WIDTH-1:0]          req_data,
  output logic [N_REQ-1:0]                     req_grant,
  input  logic                                 tx_almostfull,
  input  logic                                 wr_rsp_c0,
  input  logic                                 wr_rsp_c1,
  output logic [HDR_WIDTH-1:0]                 tx_hdr,
  output logic [DATA_WIDTH-1:0]                tx_data,
  output logic                                 tx_wrvalid,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 idle,
  output logic                                 err_underflow
);
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam int IW = $clog2(N_REQ);
  typedef struct packed {
    logic [HDR_WIDTH-1:0] hdr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;
  req_t [N_REQ-1:0] reqs;
  req_t tx_q;
  logic [IW-1:0] ptr_q, idx;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH:0] sum, ret;
  logic wrvalid_q, err_q, can_issue, any, under;
  for (genvar g = 0; g < N_REQ; g++) begin : g_req
    assign reqs[g] = '{hdr: req_hdr[g*HDR_WIDTH +: HDR_WIDTH], data: req_data[g*DATA_WIDTH +: DATA_WIDTH]};
  end
  assign can_issue = !tx_almostfull && (cnt_q < CNT_WIDTH'(MAX_OUTSTANDING));
  qa_drv_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .en_i    (can_issue && !reset),
    .grant_o (req_grant),
    .idx_o   (idx)
  );
  assign any = |req_grant;
  // Credit is taken at grant and returned by either response channel; all three may coincide
  always_comb begin
    sum = {1'b0, cnt_q} + (CNT_WIDTH+1)'(any);
    ret = (CNT_WIDTH+1)'(wr_rsp_c0) + (CNT_WIDTH+1)'(wr_rsp_c1);
    under = sum < ret;
    cnt_d = under ? '0 : CNT_WIDTH'(sum - ret);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q <= '0;
      wrvalid_q <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
      ptr_q <= IW'(N_REQ - 1);
    end else begin
      wrvalid_q <= any;
      cnt_q <= cnt_d;
      err_q <= err_q | under;
      if (any) begin
        tx_q <= reqs[idx];
        ptr_q <= idx;
      end
    end
  end
  assign tx_hdr = tx_q.hdr;
  assign tx_data = tx_q.data;
  assign tx_wrvalid = wrvalid_q;
  assign outstanding = cnt_q;
  assign err_underflow = err_q;
  assign idle = (cnt_q == '0) && (req_valid == '0);
endmodule

// File: tb/tb_qa_drv_c1_write_scheduler.sv
// tb_qa_drv_c1_write_scheduler: directed vector table plus reset and credit-cap sequences
module tb_qa_drv_c1_write_scheduler;
  localparam int N = 3, HW = 61, DW = 512, MAX = 4;
  logic clk = 1'b0, reset;
  logic [N-1:0] req_valid, req_grant;
  logic [N*HW-1:0] req_hdr;
  logic [N*DW-1:0] req_data;
  logic tx_almostfull, wr_rsp_c0, wr_rsp_c1, tx_wrvalid, idle, err_underflow;
  logic [HW-1:0] tx_hdr;
  logic [DW-1:0] tx_data;
  logic [2:0] outstanding;
  int tests = 0, failed = 0;

  qa_drv_c1_write_scheduler #(.N_REQ(N), .HDR_WIDTH(HW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_hdr(req_hdr), .req_data(req_data),
    .req_grant(req_grant), .tx_almostfull(tx_almostfull), .wr_rsp_c0(wr_rsp_c0), .wr_rsp_c1(wr_rsp_c1),
    .tx_hdr(tx_hdr), .tx_data(tx_data), .tx_wrvalid(tx_wrvalid), .outstanding(outstanding),
    .idle(idle), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] v;
    logic af, c0, c1;
    logic [2:0] g;
    logic idle;
    logic wv;
    logic [2:0] out;
    logic err;
  } vec_t;
  vec_t tv[22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [63:0] exp_hdr, exp_data;
    int ng;
    tv[0]  = '{3'b001, 0, 0, 0, 3'b001, 0, 1, 3'd1, 0};
    tv[1]  = '{3'b000, 0, 0, 1, 3'b000, 0, 0, 3'd0, 0};
    tv[2]  = '{3'b000, 0, 0, 0, 3'b000, 1, 0, 3'd0, 0};
    tv[3]  = '{3'b111, 0, 0, 0, 3'b010, 0, 1, 3'd1, 0};
    tv[4]  = '{3'b111, 0, 1, 0, 3'b100, 0, 1, 3'd1, 0};
    tv[5]  = '{3'b111, 0, 0, 1, 3'b001, 0, 1, 3'd1, 0};
    tv[6]  = '{3'b111, 0, 0, 0, 3'b010, 0, 1, 3'd2, 0};
    tv[7]  = '{3'b111, 0, 0, 0, 3'b100, 0, 1, 3'd3, 0};
    tv[8]  = '{3'b111, 0, 0, 0, 3'b001, 0, 1, 3'd4, 0};
    tv[9]  = '{3'b111, 0, 0, 0, 3'b000, 0, 0, 3'd4, 0};
    tv[10] = '{3'b111, 0, 1, 0, 3'b000, 0, 0, 3'd3, 0};
    tv[11] = '{3'b111, 0, 0, 0, 3'b010, 0, 1, 3'd4, 0};
    tv[12] = '{3'b111, 0, 1, 1, 3'b000, 0, 0, 3'd2, 0};
    tv[13] = '{3'b111, 0, 1, 1, 3'b100, 0, 1, 3'd1, 0};
    tv[14] = '{3'b110, 1, 0, 0, 3'b000, 0, 0, 3'd1, 0};
    tv[15] = '{3'b110, 1, 0, 0, 3'b000, 0, 0, 3'd1, 0};
    tv[16] = '{3'b110, 1, 0, 0, 3'b000, 0, 0, 3'd1, 0};
    tv[17] = '{3'b110, 0, 0, 0, 3'b010, 0, 1, 3'd2, 0};
    tv[18] = '{3'b000, 0, 1, 0, 3'b000, 0, 0, 3'd1, 0};
    tv[19] = '{3'b000, 0, 1, 0, 3'b000, 0, 0, 3'd0, 0};
    tv[20] = '{3'b000, 0, 0, 1, 3'b000, 1, 0, 3'd0, 1};
    tv[21] = '{3'b000, 0, 0, 0, 3'b000, 1, 0, 3'd0, 1};
    for (int i = 0; i < N; i++) begin
      req_hdr[i*HW +: HW] = HW'(64'h10 + 64'(i));
      req_data[i*DW +: DW] = DW'(64'hA0 + 64'(i));
    end
    reset = 1'b1;
    req_valid = '0;
    tx_almostfull = 1'b0;
    wr_rsp_c0 = 1'b0;
    wr_rsp_c1 = 1'b0;
    exp_hdr = '0;
    exp_data = '0;
    #12;
    req_valid = 3'b111;
    #1;
    chk("rst_grant", 64'(req_grant), 0);
    chk("rst_wrvalid", 64'(tx_wrvalid), 0);
    chk("rst_hdr", 64'(tx_hdr), 0);
    chk("rst_out", 64'(outstanding), 0);
    chk("rst_err", 64'(err_underflow), 0);
    req_valid = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 22; i++) begin
      req_valid = tv[i].v;
      tx_almostfull = tv[i].af;
      wr_rsp_c0 = tv[i].c0;
      wr_rsp_c1 = tv[i].c1;
      #1;
      chk($sformatf("v%0d_grant", i), 64'(req_grant), 64'(tv[i].g));
      chk($sformatf("v%0d_idle", i), 64'(idle), 64'(tv[i].idle));
      if (tv[i].g != 0) begin
        exp_hdr = 64'h10 + 64'($clog2(tv[i].g));
        exp_data = 64'hA0 + 64'($clog2(tv[i].g));
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wrvalid", i), 64'(tx_wrvalid), 64'(tv[i].wv));
      chk($sformatf("v%0d_out", i), 64'(outstanding), 64'(tv[i].out));
      chk($sformatf("v%0d_err", i), 64'(err_underflow), 64'(tv[i].err));
      chk($sformatf("v%0d_hdr", i), 64'(tx_hdr), exp_hdr);
      chk($sformatf("v%0d_data", i), tx_data[63:0], exp_data);
    end
    wr_rsp_c0 = 1'b0;
    wr_rsp_c1 = 1'b0;
    req_valid = 3'b111;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_grant", 64'(req_grant), 0);
    chk("mid_rst_wrvalid", 64'(tx_wrvalid), 0);
    chk("mid_rst_hdr", 64'(tx_hdr), 0);
    chk("mid_rst_out", 64'(outstanding), 0);
    chk("mid_rst_err", 64'(err_underflow), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("post_rst_grant", 64'(req_grant), 64'(3'b001));
    req_valid = 3'b001;
    ng = 0;
    for (int i = 0; i < 8; i++) begin
      if (req_grant != 0) ng++;
      @(posedge clk);
      #2;
    end
    chk("cap_grants", 64'(ng), 64'(MAX));
    chk("cap_out", 64'(outstanding), 64'(MAX));
    wr_rsp_c0 = 1'b1;
    #1;
    chk("cap_rsp_grant", 64'(req_grant), 0);
    @(posedge clk);
    #1 wr_rsp_c0 = 1'b0;
    #1;
    chk("cap_free_out", 64'(outstanding), 64'(MAX - 1));
    chk("cap_free_grant", 64'(req_grant), 64'(3'b001));
    @(posedge clk);
    #1;
    chk("cap_refill_out", 64'(outstanding), 64'(MAX));
    chk("cap_refill_wrvalid", 64'(tx_wrvalid), 1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
